// File: rtl/fpu_pkg.sv
// fpu_pkg: shared definitions for the FPU command issuer.
//   - fpu_op_e       : command opcodes as carried on cmd_op
//   - issuer_state_e : issuer FSM states, also exposed on dbg_state
//   - operand/result widths and the WAIT timeout counter width
package fpu_pkg;

    localparam int VEC_W = 256;  // 16 lanes x 16-bit half precision
    localparam int SCL_W = 16;
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        OP_VADD = 2'b00,
        OP_VDOT = 2'b01,
        OP_SMUL = 2'b10,
        OP_RSVD = 2'b11
    } fpu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_RESP  = 2'b11
    } issuer_state_e;

endpackage

// File: rtl/fpu_cmd_issuer.sv
// fpu_cmd_issuer: accepts one FPU command at a time, drives operands and a
// one-hot op select to an external FPU, waits (bounded by TIMEOUT) for
// fpu_done, then holds the captured result as a response until consumed.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   cmd_valid/cmd_ready        command handshake
//   cmd_op, cmd_va/vb/sa/sb    opcode and operands (latched on accept)
//   fpu_va/vb/sa/sb            latched operands driven to the FPU
//   VADD, VDOT, SMUL           one-hot op select, high in ISSUE and WAIT only
//   fpu_vout/fpu_sout/fpu_done FPU result and its valid strobe
//   rsp_valid/rsp_ready        response handshake
//   rsp_vout/rsp_sout/rsp_err  captured result and error flag
//   dbg_state                  current FSM state (issuer_state_e encoding)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. The producer holds valid and its payload stable until that edge;
// the issuer never withdraws rsp_valid or changes rsp_* while waiting.
module fpu_cmd_issuer
    import fpu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   cmd_op,
    input  logic [255:0] cmd_va,
    input  logic [255:0] cmd_vb,
    input  logic [15:0]  cmd_sa,
    input  logic [15:0]  cmd_sb,
    output logic [255:0] fpu_va,
    output logic [255:0] fpu_vb,
    output logic [15:0]  fpu_sa,
    output logic [15:0]  fpu_sb,
    output logic         VADD,
    output logic         VDOT,
    output logic         SMUL,
    input  logic [255:0] fpu_vout,
    input  logic [15:0]  fpu_sout,
    input  logic         fpu_done,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [255:0] rsp_vout,
    output logic [15:0]  rsp_sout,
    output logic         rsp_err,
    output logic [1:0]   dbg_state
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = TIMEOUT[CNT_W-1:0];

    issuer_state_e    state_q, state_d;
    fpu_op_e          op_q, op_d;
    logic [VEC_W-1:0] va_q, va_d, vb_q, vb_d;
    logic [SCL_W-1:0] sa_q, sa_d, sb_q, sb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [VEC_W-1:0] rsp_vout_q, rsp_vout_d;
    logic [SCL_W-1:0] rsp_sout_q, rsp_sout_d;
    logic             rsp_err_q, rsp_err_d;
    logic             fpu_active;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        va_d       = va_q;
        vb_d       = vb_q;
        sa_d       = sa_q;
        sb_d       = sb_q;
        cnt_d      = cnt_q;
        cnt_inc    = cnt_q + 8'd1;
        rsp_vout_d = rsp_vout_q;
        rsp_sout_d = rsp_sout_q;
        rsp_err_d  = rsp_err_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d = fpu_op_e'(cmd_op);
                    va_d = cmd_va;
                    vb_d = cmd_vb;
                    sa_d = cmd_sa;
                    sb_d = cmd_sb;
                    if (fpu_op_e'(cmd_op) == OP_RSVD) begin
                        // Reserved op never reaches the FPU.
                        state_d    = ST_RESP;
                        rsp_err_d  = 1'b1;
                        rsp_vout_d = '0;
                        rsp_sout_d = '0;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                // One settle cycle for the operands; fpu_done is not looked at.
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // fpu_done is tested first so it wins over a same-cycle timeout.
                if (fpu_done) begin
                    state_d    = ST_RESP;
                    rsp_err_d  = 1'b0;
                    rsp_vout_d = fpu_vout;
                    rsp_sout_d = fpu_sout;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == TIMEOUT_C) begin
                        state_d    = ST_RESP;
                        rsp_err_d  = 1'b1;
                        rsp_vout_d = '0;
                        rsp_sout_d = '0;
                    end
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d   = ST_IDLE;
                    rsp_err_d = 1'b0;  // rsp_err only meaningful with rsp_valid
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_VADD;
            va_q       <= '0;
            vb_q       <= '0;
            sa_q       <= '0;
            sb_q       <= '0;
            cnt_q      <= '0;
            rsp_vout_q <= '0;
            rsp_sout_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            va_q       <= va_d;
            vb_q       <= vb_d;
            sa_q       <= sa_d;
            sb_q       <= sb_d;
            cnt_q      <= cnt_d;
            rsp_vout_q <= rsp_vout_d;
            rsp_sout_q <= rsp_sout_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign fpu_active = (state_q == ST_ISSUE) || (state_q == ST_WAIT);

    assign cmd_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign VADD      = fpu_active && (op_q == OP_VADD);
    assign VDOT      = fpu_active && (op_q == OP_VDOT);
    assign SMUL      = fpu_active && (op_q == OP_SMUL);
    assign fpu_va    = va_q;
    assign fpu_vb    = vb_q;
    assign fpu_sa    = sa_q;
    assign fpu_sb    = sb_q;
    assign rsp_vout  = rsp_vout_q;
    assign rsp_sout  = rsp_sout_q;
    assign rsp_err   = rsp_err_q;
    assign dbg_state = state_q;

endmodule
